// File: rtl/cpu_pipeline_ctrl.sv
// rtl/cpu_pipeline_ctrl.sv - 4-stage CPU pipeline control: decode, jump resolution, squash sequencing
// Optional perf counters built when CPU_PIPELINE_CTRL_PERF_EN is defined.
module cpu_pipeline_ctrl #(
    parameter int OPW = 5
`ifdef CPU_PIPELINE_CTRL_PERF_EN
    ,
    parameter int PERF_W = 32
`endif
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [OPW-1:0]    read_opcode,
    input  logic [OPW-1:0]    execute_opcode,
    input  logic              n,
    input  logic              z,
    input  logic              fetch_v,
    input  logic              read_v,
    input  logic              execute_v,
    input  logic              write_v,
    output logic              ctrl_fetch_v,
    output logic              ctrl_read_v,
    output logic              ctrl_execute_v,
    output logic              ctrl_write_v,
    output logic [2:0]        sel_a,
    output logic [2:0]        sel_b,
    output logic              addsub,
    output logic              ldnz,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              ld_mem_rd,
    output logic              ldr,
    output logic              ldpc,
    output logic              ldpc_7
`ifdef CPU_PIPELINE_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] o_perf_retired,
    output logic [PERF_W-1:0] o_perf_squash
`endif
);

    localparam logic [OPW-1:0] OP_MV    = 5'b00000;
    localparam logic [OPW-1:0] OP_MVI   = 5'b10000;
    localparam logic [OPW-1:0] OP_ADD   = 5'b00001;
    localparam logic [OPW-1:0] OP_ADDI  = 5'b10001;
    localparam logic [OPW-1:0] OP_SUB   = 5'b00010;
    localparam logic [OPW-1:0] OP_SUBI  = 5'b10010;
    localparam logic [OPW-1:0] OP_CMP   = 5'b00011;
    localparam logic [OPW-1:0] OP_CMPI  = 5'b10011;
    localparam logic [OPW-1:0] OP_LD    = 5'b00100;
    localparam logic [OPW-1:0] OP_ST    = 5'b00101;
    localparam logic [OPW-1:0] OP_MVHI  = 5'b10110;
    localparam logic [OPW-1:0] OP_JR    = 5'b01000;
    localparam logic [OPW-1:0] OP_JZR   = 5'b01001;
    localparam logic [OPW-1:0] OP_JNR   = 5'b01010;
    localparam logic [OPW-1:0] OP_CALLR = 5'b01100;
    localparam logic [OPW-1:0] OP_J     = 5'b11000;
    localparam logic [OPW-1:0] OP_JZ    = 5'b11001;
    localparam logic [OPW-1:0] OP_JN    = 5'b11010;
    localparam logic [OPW-1:0] OP_CALL  = 5'b11100;

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_SQUASH} state_t;

    state_t r_state;
    state_t w_next;
    logic   w_booted;
    logic   w_take;
    logic   w_ex_ok;
    logic   w_wr_ok;
    logic   w_uncond;
    logic   w_call;
    logic   w_cond_z;
    logic   w_cond_n;
    logic   w_ldr_op;
    logic   w_unused;

    assign w_unused = ^{fetch_v, execute_v};
    assign w_booted = (r_state != S_BOOT);
    assign w_wr_ok  = write_v & w_booted;

    always_comb begin
        w_uncond = 1'b0;
        w_call   = 1'b0;
        w_cond_z = 1'b0;
        w_cond_n = 1'b0;
        w_ldr_op = 1'b0;
        case (execute_opcode)
            OP_JR, OP_J:       w_uncond = 1'b1;
            OP_CALLR, OP_CALL: begin
                w_uncond = 1'b1;
                w_call   = 1'b1;
            end
            OP_JZR, OP_JZ:     w_cond_z = 1'b1;
            OP_JNR, OP_JN:     w_cond_n = 1'b1;
            OP_MV, OP_MVI, OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_LD, OP_MVHI:
                               w_ldr_op = 1'b1;
            default: ;
        endcase
    end

    // Flags are the write-cycle values; a cmp now in execute only affects later jumps.
    assign w_take    = w_wr_ok & (w_uncond | (w_cond_z & z) | (w_cond_n & n));
    assign ldpc      = w_take;
    assign ldpc_7    = w_take & w_call;
    assign ldr       = w_wr_ok & w_ldr_op;
    assign ld_mem_rd = w_wr_ok & (execute_opcode == OP_LD);
    assign w_ex_ok   = read_v & w_booted & ~w_take;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        ctrl_fetch_v   = 1'b0;
        ctrl_read_v    = 1'b0;
        ctrl_execute_v = 1'b0;
        ctrl_write_v   = 1'b0;
        case (r_state)
            S_BOOT: w_next = S_RUN;
            S_RUN, S_SQUASH: begin
                w_next         = w_take ? S_SQUASH : S_RUN;
                ctrl_fetch_v   = 1'b1;
                ctrl_read_v    = ~w_take & (r_state == S_RUN);
                ctrl_execute_v = ~w_take;
                ctrl_write_v   = ~w_take;
            end
            default: w_next = S_BOOT;
        endcase
    end

    always_comb begin
        sel_a  = 3'd0;
        sel_b  = 3'd0;
        addsub = 1'b0;
        ldnz   = 1'b0;
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        if (w_booted) begin
            case (read_opcode)
                OP_MV:   begin sel_a = 3'd1; sel_b = 3'd3; end
                OP_MVI:  begin sel_a = 3'd3; sel_b = 3'd3; end
                OP_ADD:  ldnz = 1'b1;
                OP_ADDI: begin sel_b = 3'd1; ldnz = 1'b1; end
                OP_SUB, OP_CMP:   begin addsub = 1'b1; ldnz = 1'b1; end
                OP_SUBI, OP_CMPI: begin sel_b = 3'd1; addsub = 1'b1; ldnz = 1'b1; end
                OP_LD:   mem_rd = 1'b1;
                OP_ST:   mem_wr = 1'b1;
                OP_MVHI: begin sel_a = 3'd4; sel_b = 3'd3; end
                OP_JR, OP_JZR, OP_JNR, OP_CALLR: begin sel_a = 3'd1; sel_b = 3'd3; end
                OP_J, OP_JZ, OP_JN, OP_CALL:     begin sel_a = 3'd2; sel_b = 3'd2; end
                default: ;
            endcase
            ldnz   = ldnz & w_ex_ok;
            mem_rd = mem_rd & w_ex_ok;
            mem_wr = mem_wr & w_ex_ok;
        end
    end

`ifdef CPU_PIPELINE_CTRL_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_perf_retired <= '0;
            o_perf_squash  <= '0;
        end else begin
            if (write_v & ctrl_write_v) o_perf_retired <= o_perf_retired + 1'b1;
            if (w_take)                 o_perf_squash  <= o_perf_squash + 1'b1;
        end
    end
`endif

endmodule
